// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and defaults for the load-use / control hazard controller.
// Imported by the interface, the FSM top and the optional perf counters.
package hazard_pkg;

    typedef enum logic {
        HZ_IDLE  = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_e;

    localparam int REG_AW_DEF = 5;
    localparam int PERF_W_DEF = 32;
    localparam int X0_IDX     = 0;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side bundle between the ID/EX stages and the hazard controller.
// master = pipeline (drives indices/flags), slave = hazard controller (drives enables).
interface hazard_ctrl_unit_if #(
    parameter int REG_AW = hazard_pkg::REG_AW_DEF
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              idex_mem_read;
    logic              idex_reg_write;
    logic [REG_AW-1:0] idex_rd;
    logic              ex_branch_taken;
    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_bubble;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               idex_mem_read, idex_reg_write, idex_rd, ex_branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_bubble
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               idex_mem_read, idex_reg_write, idex_rd, ex_branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_bubble
    );
endinterface

// File: rtl/hazard_ctrl_unit_perf.sv
// Stall/flush event counters, wrapping at 2^PERF_W; only instantiated when
// HAZARD_PERF_CNT_EN is defined.
module hazard_perf_counters
    import hazard_pkg::*;
#(
    parameter int PERF_W = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic [PERF_W-1:0] o_stall_cnt,
    output logic [PERF_W-1:0] o_flush_cnt
);
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_stall) r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            if (i_flush) r_flush_cnt <= r_flush_cnt + PERF_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall / branch squash controller beside the ID stage.
// Optional perf counters (stall_cnt, flush_cnt) under HAZARD_PERF_CNT_EN.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  HZ_IDLE  | comparator live; detection cycle stalls with zero latency
//  HZ_STALL | holding PC/IF-ID for the rest of LOAD_LAT; remain counts down
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    hazard_ctrl_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
`endif
);
    localparam int RW = $clog2(LOAD_LAT + 1);

    hz_state_e   r_state;
    logic [RW-1:0] r_remain;

    hz_state_e   w_next_state;
    logic [RW-1:0] w_next_remain;
    logic        w_hazard;
    logic        w_pc_write;
    logic        w_ifid_write;
    logic        w_ifid_flush;
    logic        w_idex_bubble;

    assign w_hazard = hz.idex_mem_read && hz.idex_reg_write
                   && (hz.idex_rd != REG_AW'(X0_IDX))
                   && ((hz.id_rs1_used && (hz.id_rs1 == hz.idex_rd))
                    || (hz.id_rs2_used && (hz.id_rs2 == hz.idex_rd)));

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_next_state  = r_state;
        w_next_remain = r_remain;
        if (rst) begin
            w_next_state  = HZ_IDLE;
            w_next_remain = '0;
        end else if (hz.ex_branch_taken) begin
            // Branch wins even in STALL: the ID instruction is squashed anyway.
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
            w_next_state  = HZ_IDLE;
            w_next_remain = '0;
        end else if (r_state == HZ_STALL) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            w_next_remain = r_remain - RW'(1);
            if (r_remain == RW'(1)) w_next_state = HZ_IDLE;
        end else if (w_hazard) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
                w_next_state  = HZ_STALL;
                w_next_remain = RW'(LOAD_LAT - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= HZ_IDLE;
            r_remain <= '0;
        end else begin
            r_state  <= w_next_state;
            r_remain <= w_next_remain;
        end
    end

    assign hz.pc_write    = w_pc_write;
    assign hz.ifid_write  = w_ifid_write;
    assign hz.ifid_flush  = w_ifid_flush;
    assign hz.idex_bubble = w_idex_bubble;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counters #(
        .PERF_W (PERF_W)
    ) u_perf (
        .clk         (clk),
        .rst         (rst),
        .i_stall     (!w_pc_write),
        .i_flush     (w_ifid_flush),
        .o_stall_cnt (stall_cnt),
        .o_flush_cnt (flush_cnt)
    );
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Drives four controllers (LOAD_LAT 1..4) with identical stimulus and checks
// each against a stall-window timeline model; counters checked under HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] t_rs1 = '0, t_rs2 = '0, t_rd = '0;
    logic       t_u1 = 1'b0, t_u2 = 1'b0, t_mr = 1'b0, t_rw = 1'b0, t_br = 1'b0;

    logic [3:0] obs [4];   // {pc_write, ifid_write, ifid_flush, idex_bubble}
    logic [3:0] exp_o [4];
    int         rel [4];   // first cycle index no longer inside the stall window
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc [4], fc [4];
    logic [31:0] m_sc [4], m_fc [4], exp_sc [4], exp_fc [4];
`endif

    for (genvar g = 0; g < 4; g++) begin : g_dut
        hazard_ctrl_unit_if #(.REG_AW(5)) u_if ();
        assign u_if.id_rs1          = t_rs1;
        assign u_if.id_rs2          = t_rs2;
        assign u_if.id_rs1_used     = t_u1;
        assign u_if.id_rs2_used     = t_u2;
        assign u_if.idex_mem_read   = t_mr;
        assign u_if.idex_reg_write  = t_rw;
        assign u_if.idex_rd         = t_rd;
        assign u_if.ex_branch_taken = t_br;
        assign obs[g] = {u_if.pc_write, u_if.ifid_write, u_if.ifid_flush, u_if.idex_bubble};
        hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(g + 1), .PERF_W(32)) u_dut (
            .clk (clk),
            .rst (rst),
            .hz  (u_if)
`ifdef HAZARD_PERF_CNT_EN
            ,
            .stall_cnt (sc[g]),
            .flush_cnt (fc[g])
`endif
        );
    end

    // Apply one cycle of inputs at the falling edge and predict outputs for it.
    task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic mr, input logic rw,
                         input logic [4:0] rd, input logic br);
        logic hzd;
        @(negedge clk);
        rst = r; t_rs1 = rs1; t_rs2 = rs2; t_u1 = u1; t_u2 = u2;
        t_mr = mr; t_rw = rw; t_rd = rd; t_br = br;
        hzd = mr && rw && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        for (int k = 0; k < 4; k++) begin
`ifdef HAZARD_PERF_CNT_EN
            exp_sc[k] = m_sc[k];
            exp_fc[k] = m_fc[k];
`endif
            if (r) begin
                exp_o[k] = 4'b1100; rel[k] = 0;
            end else if (br) begin
                exp_o[k] = 4'b1111; rel[k] = 0;
            end else if (cyc < rel[k]) begin
                exp_o[k] = 4'b0001;
            end else if (hzd) begin
                exp_o[k] = 4'b0001; rel[k] = cyc + k + 1;
            end else begin
                exp_o[k] = 4'b1100;
            end
`ifdef HAZARD_PERF_CNT_EN
            if (r) begin
                m_sc[k] = '0; m_fc[k] = '0;
            end else begin
                if (!exp_o[k][3]) m_sc[k] = m_sc[k] + 32'd1;
                if (exp_o[k][1])  m_fc[k] = m_fc[k] + 32'd1;
            end
`endif
        end
        cyc++;
        #1;
    endtask

    task automatic idle_in();
        drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0);
    endtask

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (obs[k] !== 4'b1100 || obs[k] !== exp_o[k]) begin
                    fails++;
                    $display("FAIL reset lat=%0d got=%b want=%b", k + 1, obs[k], exp_o[k]);
                end
`ifdef HAZARD_PERF_CNT_EN
                tests++;
                if (n > 0 && (sc[k] !== 32'd0 || fc[k] !== 32'd0)) begin
                    fails++;
                    $display("FAIL reset_cnt lat=%0d got=%0d/%0d want=0/0", k + 1, sc[k], fc[k]);
                end
`endif
            end
        end
    endtask

    task automatic test_idle_run(input int n);
        for (int i = 0; i < n; i++) begin
            idle_in();
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (obs[k] !== exp_o[k]) begin
                    fails++;
                    $display("FAIL idle lat=%0d got=%b want=%b", k + 1, obs[k], exp_o[k]);
                end
            end
        end
    endtask

    task automatic test_single_cycle_stall();
        drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
        tests++;
        if (obs[0] !== 4'b0001) begin
            fails++;
            $display("FAIL lat1_detect got=%b want=0001", obs[0]);
        end
        idle_in();
        tests++;
        if (obs[0] !== 4'b1100) begin
            fails++;
            $display("FAIL lat1_release got=%b want=1100", obs[0]);
        end
        for (int k = 1; k < 4; k++) begin
            tests++;
            if (obs[k] !== exp_o[k]) begin
                fails++;
                $display("FAIL lat1_others lat=%0d got=%b want=%b", k + 1, obs[k], exp_o[k]);
            end
        end
    endtask

    task automatic test_multi_cycle_stall();
        int stalls;
`ifdef HAZARD_PERF_CNT_EN
        logic [31:0] sc0;
        sc0 = sc[2];
`endif
        stalls = 0;
        drive(1'b0, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) idle_in();
            if (obs[2] === 4'b0001) stalls++;
            tests++;
            if (obs[2] !== exp_o[2]) begin
                fails++;
                $display("FAIL lat3_cycle i=%0d got=%b want=%b", i, obs[2], exp_o[2]);
            end
        end
        tests++;
        if (stalls != 3) begin
            fails++;
            $display("FAIL lat3_len got=%0d want=3", stalls);
        end
`ifdef HAZARD_PERF_CNT_EN
        tests++;
        if (sc[2] - sc0 !== 32'd3) begin
            fails++;
            $display("FAIL lat3_stall_cnt got=%0d want=3", sc[2] - sc0);
        end
`endif
    endtask

    task automatic test_no_hazard();
        drive(1'b0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (obs[k] !== 4'b1100) begin
                fails++;
                $display("FAIL x0 lat=%0d got=%b want=1100", k + 1, obs[k]);
            end
        end
        drive(1'b0, 5'd5, 5'd6, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (obs[k] !== 4'b1100) begin
                fails++;
                $display("FAIL unused_src lat=%0d got=%b want=1100", k + 1, obs[k]);
            end
        end
    endtask

    task automatic test_branch();
`ifdef HAZARD_PERF_CNT_EN
        logic [31:0] fc0;
        fc0 = fc[1];
`endif
        drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (obs[k] !== 4'b1111) begin
                fails++;
                $display("FAIL branch lat=%0d got=%b want=1111", k + 1, obs[k]);
            end
        end
        idle_in();
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (obs[k] !== 4'b1100) begin
                fails++;
                $display("FAIL branch_after lat=%0d got=%b want=1100", k + 1, obs[k]);
            end
        end
`ifdef HAZARD_PERF_CNT_EN
        tests++;
        if (fc[1] - fc0 !== 32'd1) begin
            fails++;
            $display("FAIL branch_flush_cnt got=%0d want=1", fc[1] - fc0);
        end
`endif
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
        idle_in();
        tests++;
        if (obs[3] !== 4'b0001) begin
            fails++;
            $display("FAIL rstmid_stall got=%b want=0001", obs[3]);
        end
        drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
        tests++;
        if (obs[3] !== 4'b1100) begin
            fails++;
            $display("FAIL rstmid_during got=%b want=1100", obs[3]);
        end
        for (int i = 0; i < 2; i++) begin
            idle_in();
            tests++;
            if (obs[3] !== 4'b1100) begin
                fails++;
                $display("FAIL rstmid_after i=%0d got=%b want=1100", i, obs[3]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] hz_pat;
        logic [5:0] pw_seen;
        hz_pat = 6'b001001;   // bit i = hazard presented in cycle i
        for (int i = 0; i < 6; i++) begin
            if (hz_pat[i]) drive(1'b0, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 1'b0);
            else idle_in();
            pw_seen[i] = obs[1][3];
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (obs[k] !== exp_o[k]) begin
                    fails++;
                    $display("FAIL b2b lat=%0d i=%0d got=%b want=%b", k + 1, i, obs[k], exp_o[k]);
                end
            end
        end
        tests++;
        if (pw_seen !== 6'b100100) begin
            fails++;
            $display("FAIL b2b_lat2_pattern got=%b want=100100", pw_seen);
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            drive(($urandom_range(0, 39) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0));
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (obs[k] !== exp_o[k]) begin
                    fails++;
                    $display("FAIL random lat=%0d cyc=%0d got=%b want=%b", k + 1, cyc, obs[k], exp_o[k]);
                end
`ifdef HAZARD_PERF_CNT_EN
                tests++;
                if (sc[k] !== exp_sc[k] || fc[k] !== exp_fc[k]) begin
                    fails++;
                    $display("FAIL random_cnt lat=%0d got=%0d/%0d want=%0d/%0d",
                             k + 1, sc[k], fc[k], exp_sc[k], exp_fc[k]);
                end
`endif
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rel[k] = 0;
            exp_o[k] = 4'b1100;
`ifdef HAZARD_PERF_CNT_EN
            m_sc[k] = '0; m_fc[k] = '0; exp_sc[k] = '0; exp_fc[k] = '0;
`endif
        end
        test_reset();
        test_single_cycle_stall();
        test_idle_run(4);
        test_multi_cycle_stall();
        test_idle_run(4);
        test_no_hazard();
        test_branch();
        test_reset_mid_stall();
        test_idle_run(4);
        test_back_to_back();
        test_idle_run(4);
        test_random(400);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised load-use and control-hazard controller for the 5-stage RV32 pipeline, sitting beside the ID stage. Compares ID-stage source registers against the load in ID/EX, stalls PC and IF/ID for a configurable memory latency via a countdown FSM, and inserts bubbles into ID/EX. Squashes IF/ID on taken branches resolved in EX. Optionally keeps stall and flush performance counters.

## Interface
- REG_AW, 5, register-index width.
- LOAD_LAT, 1, load-use stall cycles (≥1); 1 = single-cycle data memory.
- PERF_W, 32, performance-counter width (used only with HAZARD_PERF_CNT_EN).

- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  REG_AW  source indices of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1  the source is actually read; U/J types clear these.
- idex_mem_read  in  1  the instruction in ID/EX is a load.
- idex_reg_write  in  1  the instruction in ID/EX writes rd.
- idex_rd  in  REG_AW  destination of the instruction in ID/EX.
- ex_branch_taken  in  1  taken branch or jump resolved in EX this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_bubble  out  1  load NOP (control zeroed) into ID/EX.
- stall_cnt, flush_cnt  out  PERF_W  perf counters (HAZARD_PERF_CNT_EN only).

## Operation
- Hazard = idex_mem_read & idex_reg_write & (idex_rd≠0) & ((id_rs1_used & id_rs1==idex_rd) | (id_rs2_used & id_rs2==idex_rd)). x0 never hazards.
- FSM states: IDLE, STALL. Counter `remain`, width clog2(LOAD_LAT+1).
- IDLE, ex_branch_taken=1: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. Stay IDLE. Hazard is ignored, because the ID instruction is squashed.
- IDLE, hazard, no branch: pc_write=0, ifid_write=0, idex_bubble=1.
  - LOAD_LAT==1: stay IDLE.
  - Otherwise: go to STALL with remain=LOAD_LAT-1.
- IDLE, neither condition: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- STALL: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0. The hazard comparator is not evaluated.
  - remain decrements each cycle. On the cycle remain==1, next state is IDLE.
  - ex_branch_taken in STALL is a protocol violation, since EX holds a bubble. The required response: branch wins, flush outputs as in IDLE, next state IDLE, remain cleared.
- Outputs are combinational from state and inputs. No registered outputs apart from the counters.

## Timing
- Detection is zero-latency: the stall is asserted in the same cycle the hazard is present in ID/EX.
- Total stall length = exactly LOAD_LAT cycles, counting the detection cycle.
- On the first cycle after the stall window: pc_write=ifid_write=1. The comparator is re-evaluated against the new ID/EX contents, so back-to-back load-use hazards re-stall without a gap.
- While rst=1, and at the first edge after reset:
  - state=IDLE, remain=0, counters=0.
  - Outputs are forced to pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- Reset mid-STALL aborts the stall. The next cycle after deassertion is IDLE.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on every cycle with pc_write=0.
  - flush_cnt increments on every cycle with ifid_flush=1.
  - Both wrap at 2^PERF_W and clear on rst.
- HAZARD_PERF_CNT_EN undefined: the stall_cnt/flush_cnt ports and their logic are absent.

## Structure
- Shared package hazard_pkg contains:
  - the state enum (HZ_IDLE, HZ_STALL);
  - default REG_AW=5 and PERF_W=32;
  - the x0 index constant.
- One sub-module, hazard_perf_counters, instantiated only under HAZARD_PERF_CNT_EN. The FSM stays in the top.

## Test plan
- LOAD_LAT=1, idex_mem_read=1, idex_reg_write=1, idex_rd=5, id_rs1=5, used=1 → one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then all released.
- LOAD_LAT=3, same hazard on id_rs2=7 → exactly 3 stall cycles. With HAZARD_PERF_CNT_EN, stall_cnt=3 afterwards.
- idex_rd=0 with id_rs1=0; also id_rs1=5 with id_rs1_used=0 → no stall.
- ex_branch_taken=1 coincident with a hazard → ifid_flush=1, idex_bubble=1, pc_write=1, no stall. flush_cnt=1.
- LOAD_LAT=4, rst asserted in the 2nd STALL cycle → outputs released during reset. IDLE, remain=0 after deassertion.
- Two consecutive loads each feeding the next instruction (LOAD_LAT=2) → two 2-cycle stalls separated by one released cycle.
